pcap_capture_qwriter: RTL

//  Write side of the per-queue pcap replay memory. Takes ingress AXI-Stream packets, selects a queue from the

---
 rtl/pcap_capture_qwriter_if.sv | 37 +++
 rtl/pcap_capture_qwriter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pcap_capture_qwriter_if.sv
// Ingress AXI-Stream plus memory write-request bundle of the pcap capture writer.
interface pcap_capture_qwriter_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int ADDR_WIDTH  = 19
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic [TUSER_WIDTH-1:0]  s_axis_tuser;
  logic                    s_axis_tvalid;
  logic                    s_axis_tlast;
  logic                    s_axis_tready;

  logic                    mem_wr_valid;
  logic                    mem_wr_ready;
  logic [ADDR_WIDTH-1:0]   mem_wr_addr;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH/8-1:0] mem_wr_strb;
  logic                    mem_wr_sop;
  logic                    mem_wr_last;

  // Environment side: packet source upstream, memory downstream.
  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, mem_wr_sop, mem_wr_last,
    output mem_wr_ready
  );

  // Writer side.
  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, mem_wr_sop, mem_wr_last,
    input  mem_wr_ready
  );
endinterface

// File: rtl/pcap_capture_qwriter.sv
// Write side of the per-queue pcap replay memory: admits whole packets into a
// queue region selected from the tuser source-port field and publishes a
// committed write pointer per queue for the replay reader.
module pcap_capture_qwriter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_SRC_PORT_WIDTH     = 8,
  parameter int C_TUSER_SRC_PORT_POS = 24,
  parameter int C_NUM_QUEUES         = 4,
  parameter int QDR_ADDR_WIDTH       = 19,
  parameter int C_MAX_PKT_BEATS      = 64
) (
  input  logic                                     axi_aclk,
  input  logic                                     axi_aresetn,
  input  logic                                     sw_rst,
  pcap_capture_qwriter_if.slave                    bus,
  input  logic [C_NUM_QUEUES-1:0]                  enable_q,
  input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]   mem_ad_low,
  input  logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]   mem_ad_high,
  output logic [C_NUM_QUEUES*QDR_ADDR_WIDTH-1:0]   commit_ptr,
  output logic [C_NUM_QUEUES-1:0]                  q_full,
  output logic [C_NUM_QUEUES*32-1:0]               pkt_count,
  output logic [31:0]                              drop_count
);
  localparam int NQ = C_NUM_QUEUES;
  localparam int QA = QDR_ADDR_WIDTH;
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam logic [QA:0] MAX_BEATS = (QA+1)'(C_MAX_PKT_BEATS);
  localparam logic [QA:0] ONE_W     = (QA+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   q_sel_q, q_sel_d;
  logic            sop_q, sop_d;
  logic [QA-1:0]   wr_ptr_q [NQ];
  logic [QA-1:0]   wr_ptr_d [NQ];
  logic [QA-1:0]   commit_q [NQ];
  logic [QA-1:0]   commit_d [NQ];
  logic [31:0]     pkt_q    [NQ];
  logic [31:0]     pkt_d    [NQ];
  logic [31:0]     drop_q, drop_d;
  logic [NQ-1:0]   q_full_q, q_full_d;

  logic [QA-1:0]               ad_low  [NQ];
  logic [QA-1:0]               ad_high [NQ];
  logic [C_SRC_PORT_WIDTH-1:0] src_port;
  logic                        sel_found;
  logic [QW-1:0]               sel_idx;
  logic [QA:0]                 room;
  logic                        space_ok;
  logic                        tready_c;
  logic                        wr_valid_c;
  logic                        accept;
  logic                        unused_tuser;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Unpack bounds, pick the lowest queue flagged in the source-port field and test its free space.
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      ad_low[i]  = mem_ad_low[i*QA +: QA];
      ad_high[i] = mem_ad_high[i*QA +: QA];
    end
    src_port  = bus.s_axis_tuser[C_TUSER_SRC_PORT_POS +: C_SRC_PORT_WIDTH];
    sel_found = 1'b0;
    sel_idx   = '0;
    // Walk downward so the lowest flagged queue is the one left standing.
    for (int i = NQ - 1; i >= 0; i--) begin
      if (src_port[2*i] || src_port[2*i+1]) begin
        sel_found = 1'b1;
        sel_idx   = QW'(i);
      end
    end
    // One extra bit catches high < wr_ptr (including low > high) as a borrow.
    room     = {1'b0, ad_high[sel_idx]} - {1'b0, wr_ptr_q[sel_idx]};
    space_ok = !room[QA] && ((room + ONE_W) >= MAX_BEATS);
  end

  // Packet FSM, beat pass-through, pointer/counter updates and pointer reloads.
  always_comb begin
    // NOTE: every variable gets a default here so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    q_sel_d    = q_sel_q;
    sop_d      = sop_q;
    wr_ptr_d   = wr_ptr_q;
    commit_d   = commit_q;
    pkt_d      = pkt_q;
    drop_d     = drop_q;
    q_full_d   = q_full_q;
    tready_c   = 1'b0;
    wr_valid_c = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Decision cycle only; the first beat stays on the bus until WRITE or DROP.
        if (!sw_rst && bus.s_axis_tvalid) begin
          if (sel_found && enable_q[sel_idx] && space_ok) begin
            state_d = ST_WRITE;
            q_sel_d = sel_idx;
            sop_d   = 1'b1;
          end else begin
            state_d = ST_DROP;
            drop_d  = sat_inc(drop_q);
            if (sel_found && enable_q[sel_idx]) q_full_d[sel_idx] = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (sw_rst) begin
          // Abandon the packet: nothing more is written and nothing is committed.
          tready_c = 1'b1;
          state_d  = (bus.s_axis_tvalid && bus.s_axis_tlast) ? ST_IDLE : ST_DROP;
        end else begin
          wr_valid_c = bus.s_axis_tvalid;
          tready_c   = bus.mem_wr_ready;
          accept     = bus.s_axis_tvalid && bus.mem_wr_ready;
          if (accept) begin
            wr_ptr_d[q_sel_q] = wr_ptr_q[q_sel_q] + 1'b1;
            sop_d             = 1'b0;
            if (bus.s_axis_tlast) begin
              commit_d[q_sel_q] = wr_ptr_q[q_sel_q] + 1'b1;
              pkt_d[q_sel_q]    = sat_inc(pkt_q[q_sel_q]);
              state_d           = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        tready_c = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A disabled queue tracks its low bound, except the queue finishing a packet in WRITE.
    for (int i = 0; i < NQ; i++) begin
      if (sw_rst || (!enable_q[i] && !(state_q == ST_WRITE && q_sel_q == QW'(i)))) begin
        wr_ptr_d[i] = ad_low[i];
        commit_d[i] = ad_low[i];
        q_full_d[i] = 1'b0;
      end
    end
    if (sw_rst) begin
      for (int i = 0; i < NQ; i++) pkt_d[i] = '0;
      drop_d = '0;
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q  <= ST_IDLE;
      q_sel_q  <= '0;
      sop_q    <= 1'b0;
      drop_q   <= '0;
      q_full_q <= '0;
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= '0;
        commit_q[i] <= '0;
        pkt_q[i]    <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      q_sel_q  <= q_sel_d;
      sop_q    <= sop_d;
      drop_q   <= drop_d;
      q_full_q <= q_full_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      pkt_q    <= pkt_d;
    end
  end

  assign bus.s_axis_tready = tready_c;
  assign bus.mem_wr_valid  = wr_valid_c;
  assign bus.mem_wr_addr   = wr_ptr_q[q_sel_q];
  assign bus.mem_wr_data   = bus.s_axis_tdata;
  assign bus.mem_wr_strb   = bus.s_axis_tstrb;
  assign bus.mem_wr_sop    = sop_q;
  assign bus.mem_wr_last   = bus.s_axis_tlast;

  // Only the source-port field of tuser is meaningful to this block.
  assign unused_tuser = ^bus.s_axis_tuser;

  genvar g;
  generate
    for (g = 0; g < NQ; g++) begin : g_out
      assign commit_ptr[g*QA +: QA] = commit_q[g];
      assign pkt_count[g*32 +: 32]  = pkt_q[g];
    end
  endgenerate

  assign q_full     = q_full_q;
  assign drop_count = drop_q;

endmodule
